// File: rtl/neonfox_mem_pkg.sv
// rtl/neonfox_mem_pkg.sv - shared types and constants for the NeonFox memory port arbiter
//
// Purpose: port-id and arbiter-state enums plus the controller geometry
// (word-address width, burst length) shared by the arbiter and its picker.
package neonfox_mem_pkg;

   localparam int ADDR_W    = 24;
   localparam int BURST_LEN = 4;

   typedef enum logic [1:0] {
      PORT_NONE = 2'd0,
      PORT_P1   = 2'd1,
      PORT_P2   = 2'd2,
      PORT_P3   = 2'd3
   } port_id_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_rr_pick.sv
// rtl/mem_port_rr_pick.sv - combinational winner picker for the three memory clients
//
// Purpose: chooses the next burst owner from the pending requests.
// Ports:
//   reqs_i     [3:1] pending requests, bit N = port N
//   last_rr_i        port granted most recently
//   winner_o         chosen port, PORT_NONE when nothing is pending
module mem_port_rr_pick
   import neonfox_mem_pkg::*;
(
   input  logic [3:1] reqs_i,
   input  port_id_t   last_rr_i,
   output port_id_t   winner_o
);

   // Rotation p1 -> p2 -> p3 -> p1, starting after the last grant. Since the
   // reset value of last_rr is p2, p3 leads the first arbitration and p1 beats
   // p2 on the first tie; p3 always comes next after a p2 burst, so a display
   // request raised during a p2 burst is served before a pending p1 fill.
   always_comb begin
      winner_o = PORT_NONE;
      case (last_rr_i)
         PORT_P1: begin
            if (reqs_i[2])      winner_o = PORT_P2;
            else if (reqs_i[3]) winner_o = PORT_P3;
            else if (reqs_i[1]) winner_o = PORT_P1;
         end
         PORT_P3: begin
            if (reqs_i[1])      winner_o = PORT_P1;
            else if (reqs_i[2]) winner_o = PORT_P2;
            else if (reqs_i[3]) winner_o = PORT_P3;
         end
         default: begin
            if (reqs_i[3])      winner_o = PORT_P3;
            else if (reqs_i[1]) winner_o = PORT_P1;
            else if (reqs_i[2]) winner_o = PORT_P2;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-client burst arbiter in front of the SDRAM controller
//
// Purpose: grants one client a whole 4-word burst, holds address/direction
// stable for the burst and routes beat strobes, beat index and write data.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   p1_*                            program-cache fill port (read only)
//   p2_*                            data-cache fill/writeback port
//   p3_*                            display/DMA port
//   ctl_req_o/wren_o/address_o      registered burst request to the controller
//   ctl_to_mem_o                    write data of the granted port
//   ctl_ready_i/offset_i            controller beat strobe and beat index
module mem_port_arbiter
   import neonfox_mem_pkg::*;
#(
   parameter int ADDR_W    = neonfox_mem_pkg::ADDR_W,
   parameter int BURST_LEN = neonfox_mem_pkg::BURST_LEN
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p1_req_i,
   input  logic [31:0]       p1_address_i,
   output logic              p1_ready_o,
   output logic [1:0]        p1_offset_o,
   input  logic              p2_req_i,
   input  logic              p2_wren_i,
   input  logic [31:0]       p2_address_i,
   input  logic [15:0]       p2_to_mem_i,
   output logic              p2_ready_o,
   output logic [1:0]        p2_offset_o,
   input  logic              p3_req_i,
   input  logic              p3_wren_i,
   input  logic [23:0]       p3_address_i,
   input  logic [15:0]       p3_to_mem_i,
   output logic              p3_ready_o,
   output logic [1:0]        p3_offset_o,
   output logic              ctl_req_o,
   output logic              ctl_wren_o,
   output logic [ADDR_W-1:0] ctl_address_o,
   output logic [15:0]       ctl_to_mem_o,
   input  logic              ctl_ready_i,
   input  logic [1:0]        ctl_offset_i
);

   localparam logic [1:0] LAST_OFFSET = 2'(BURST_LEN - 1);

   arb_state_t        state_q;
   port_id_t          grant_q;
   port_id_t          last_rr_q;
   port_id_t          winner;
   logic              ctl_req_q;
   logic              ctl_wren_q;
   logic [ADDR_W-1:0] ctl_address_q;
   logic [3:0]        beat_cnt_q;
   logic [3:1]        reqs;

   assign reqs = {p3_req_i, p2_req_i, p1_req_i};

   mem_port_rr_pick u_pick (
      .reqs_i    (reqs),
      .last_rr_i (last_rr_q),
      .winner_o  (winner)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         grant_q       <= PORT_NONE;
         last_rr_q     <= PORT_P2;
         ctl_req_q     <= 1'b0;
         ctl_wren_q    <= 1'b0;
         ctl_address_q <= '0;
         beat_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (winner != PORT_NONE) begin
                  state_q    <= BUSY;
                  grant_q    <= winner;
                  last_rr_q  <= winner;
                  ctl_req_q  <= 1'b1;
                  beat_cnt_q <= '0;
                  case (winner)
                     PORT_P1: begin
                        ctl_address_q <= ADDR_W'(p1_address_i);
                        ctl_wren_q    <= 1'b0;
                     end
                     PORT_P2: begin
                        ctl_address_q <= ADDR_W'(p2_address_i);
                        ctl_wren_q    <= p2_wren_i;
                     end
                     default: begin
                        ctl_address_q <= ADDR_W'(p3_address_i);
                        ctl_wren_q    <= p3_wren_i;
                     end
                  endcase
               end
            end
            BUSY: begin
               if (ctl_ready_i) begin
                  if (ctl_offset_i == LAST_OFFSET) begin
                     // Grant is dropped here so nothing is routed during DONE.
                     state_q    <= DONE;
                     grant_q    <= PORT_NONE;
                     ctl_req_q  <= 1'b0;
                     beat_cnt_q <= '0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 4'd1;
                  end
               end
            end
            DONE: begin
               // Requests are not sampled here, giving the finished client a cycle to drop req.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ctl_req_o     = ctl_req_q;
   assign ctl_wren_o    = ctl_wren_q;
   assign ctl_address_o = ctl_address_q;

   // Beat routing follows the registered grant, so readys drop with reset at once.
   always_comb begin
      p1_ready_o   = 1'b0;
      p1_offset_o  = 2'd0;
      p2_ready_o   = 1'b0;
      p2_offset_o  = 2'd0;
      p3_ready_o   = 1'b0;
      p3_offset_o  = 2'd0;
      ctl_to_mem_o = 16'd0;
      case (grant_q)
         PORT_P1: begin
            p1_ready_o  = ctl_ready_i;
            p1_offset_o = ctl_offset_i;
         end
         PORT_P2: begin
            p2_ready_o   = ctl_ready_i;
            p2_offset_o  = ctl_offset_i;
            ctl_to_mem_o = p2_to_mem_i;
         end
         PORT_P3: begin
            p3_ready_o   = ctl_ready_i;
            p3_offset_o  = ctl_offset_i;
            ctl_to_mem_o = p3_to_mem_i;
         end
         default: begin
         end
      endcase
   end

endmodule
